// File: rtl/fixed_point_acc_pkg.sv
// Shared types and helpers for the lane-parallel fixed-point accumulator.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package fixed_point_acc_pkg;

    // Control states of the accumulator sequencer
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ACCUMULATE = 2'd1,
        ST_REDUCE     = 2'd2,
        ST_DONE       = 2'd3
    } acc_state_t;

    // Internal width wide enough that the sum of num_inputs operands plus a
    // bias of the same width can never overflow.
    function automatic int calc_iw(input int width, input int num_inputs);
        return width + $clog2(num_inputs + 1);
    endfunction

    // Largest two's-complement value representable in 'width' bits
    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    // Smallest two's-complement value representable in 'width' bits
    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/fixed_point_sat.sv
// Narrows an IW-bit signed sum to WIDTH bits; clips when FIXED_POINT_ACC_SAT_EN is defined, else wraps.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result when it wants it.
module fixed_point_sat
    import fixed_point_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IW    = 13
) (
    input  logic signed [IW-1:0]    sum,
    output logic        [WIDTH-1:0] value,
    output logic                    overflow
);

`ifdef FIXED_POINT_ACC_SAT_EN
    localparam logic signed [IW-1:0] MAX_V = IW'(sat_max(WIDTH));
    localparam logic signed [IW-1:0] MIN_V = IW'(sat_min(WIDTH));

    // Clip to the representable WIDTH-bit range and flag when clipping happened
    always_comb begin
        value    = sum[WIDTH-1:0];
        overflow = 1'b0;
        if (sum > MAX_V) begin
            value    = MAX_V[WIDTH-1:0];
            overflow = 1'b1;
        end else if (sum < MIN_V) begin
            value    = MIN_V[WIDTH-1:0];
            overflow = 1'b1;
        end
    end
`else
    // Wrap mode simply drops the guard bits; they are intentionally discarded.
    logic unused_hi_bits;
    assign unused_hi_bits = ^sum[IW-1:WIDTH];
    assign value          = sum[WIDTH-1:0];
    assign overflow       = 1'b0;
`endif

endmodule

// File: rtl/fixed_point_acc_lanes.sv
// Sums NUM_INPUTS signed Qm.FRAC_BITS operands (+ optional bias) on NUM_LANES parallel adders; macro FIXED_POINT_ACC_SAT_EN selects saturation.
// Latency: acceptance at edge t -> VALID_OUT at edge t+K+1 (K = NUM_INPUTS/NUM_LANES); one vector in flight.
// Backpressure: READY_OUT low from acceptance until the result handshakes; result held while READY_IN is low.
module fixed_point_acc_lanes
    import fixed_point_acc_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FRAC_BITS    = 3,
    parameter int NUM_INPUTS   = 16,
    parameter int NUM_LANES    = 4,
    parameter bit HAS_EXT_BIAS = 1'b0
) (
    input  logic                          CLK,
    input  logic                          RSTN,
    input  logic [NUM_INPUTS*WIDTH-1:0]   VALUES_IN,
    input  logic [WIDTH-1:0]              EXT_VALUE_IN,
    input  logic                          VALID_IN,
    output logic                          READY_OUT,
    output logic [WIDTH-1:0]              VALUE_OUT,
    output logic                          VALID_OUT,
    input  logic                          READY_IN,
    output logic                          OVERFLOW_OUT
);

    localparam int IW = calc_iw(WIDTH, NUM_INPUTS);
    localparam int K  = NUM_INPUTS / NUM_LANES;
    localparam int BW = (K > 1) ? $clog2(K) : 1;

    // Operands share the result Q format, so FRAC_BITS only needs validating.
    if (FRAC_BITS <= 0 || NUM_LANES < 1 || NUM_LANES > NUM_INPUTS ||
        (NUM_INPUTS % NUM_LANES) != 0) begin : g_bad_params
        $error("fixed_point_acc_lanes: illegal parameter combination");
    end

    acc_state_t                   state_q, state_next;
    logic [NUM_INPUTS*WIDTH-1:0]  vals_q;
    logic [WIDTH-1:0]             bias_q;
    logic signed [IW-1:0]         lane_acc [NUM_LANES];
    logic [BW-1:0]                beat_q;
    logic                         accept;
    logic                         last_beat;
    logic signed [IW-1:0]         red_sum;
    logic [WIDTH-1:0]             sat_value;
    logic                         sat_ovf;

    assign accept    = (state_q == ST_IDLE) && VALID_IN && READY_OUT;
    assign last_beat = (beat_q == BW'(K - 1));

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state sequencing: IDLE -> ACCUMULATE (K beats) -> REDUCE -> DONE -> IDLE
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_IDLE:       if (accept)    state_next = ST_ACCUMULATE;
            ST_ACCUMULATE: if (last_beat) state_next = ST_REDUCE;
            ST_REDUCE:                    state_next = ST_DONE;
            ST_DONE:       if (READY_IN)  state_next = ST_IDLE;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // Capture the vector on acceptance, then feed one lane-group per beat by
    // shifting the captured operands down so lane j always reads slot j.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vals_q <= '0;
            bias_q <= '0;
            beat_q <= '0;
            for (int j = 0; j < NUM_LANES; j++) begin
                lane_acc[j] <= '0;
            end
        end else if (accept) begin
            vals_q <= VALUES_IN;
            bias_q <= EXT_VALUE_IN;
            beat_q <= '0;
            for (int j = 0; j < NUM_LANES; j++) begin
                lane_acc[j] <= '0;
            end
        end else if (state_q == ST_ACCUMULATE) begin
            vals_q <= vals_q >> (NUM_LANES * WIDTH);
            beat_q <= beat_q + 1'b1;
            for (int j = 0; j < NUM_LANES; j++) begin
                lane_acc[j] <= lane_acc[j] + IW'(signed'(vals_q[j*WIDTH +: WIDTH]));
            end
        end
    end

    // Reduction tree: all lane partial sums plus the sign-extended bias
    always_comb begin
        red_sum = HAS_EXT_BIAS ? IW'(signed'(bias_q)) : '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            red_sum = red_sum + lane_acc[j];
        end
    end

    fixed_point_sat #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_sat (
        .sum      (red_sum),
        .value    (sat_value),
        .overflow (sat_ovf)
    );

    // Output registers: result loaded in REDUCE and held through DONE;
    // READY_OUT tracks whether the next state is IDLE.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            READY_OUT    <= 1'b0;
            VALID_OUT    <= 1'b0;
            VALUE_OUT    <= '0;
            OVERFLOW_OUT <= 1'b0;
        end else begin
            READY_OUT <= (state_next == ST_IDLE);
            if (state_q == ST_REDUCE) begin
                VALUE_OUT    <= sat_value;
                OVERFLOW_OUT <= sat_ovf;
                VALID_OUT    <= 1'b1;
            end else if (state_q == ST_DONE && READY_IN) begin
                VALID_OUT <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_point_acc_lanes.sv
// Randomised and directed bench for fixed_point_acc_lanes, with and without bias, against a plain-arithmetic model.
// Latency: checks VALID_OUT arrives K+1 edges after acceptance and the K+2 minimum period.
// Backpressure: exercises READY_IN held low, ignored VALID_IN pulses and reset mid-vector.
module tb_fixed_point_acc_lanes;

    localparam int W  = 8;
    localparam int NI = 16;
    localparam int NL = 4;
    localparam int K  = NI / NL;

    logic            CLK = 1'b0;
    logic            RSTN = 1'b0;
    logic [NI*W-1:0] VALUES_IN = '0;
    logic [W-1:0]    EXT_VALUE_IN = '0;
    logic            VALID_IN = 1'b0;
    logic            READY_IN = 1'b0;

    logic            rdy_n, vld_n, ovf_n;
    logic [W-1:0]    val_n;
    logic            rdy_b, vld_b, ovf_b;
    logic [W-1:0]    val_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    fixed_point_acc_lanes #(
        .WIDTH(W), .FRAC_BITS(3), .NUM_INPUTS(NI), .NUM_LANES(NL), .HAS_EXT_BIAS(1'b0)
    ) dut_n (
        .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .EXT_VALUE_IN(EXT_VALUE_IN),
        .VALID_IN(VALID_IN), .READY_OUT(rdy_n), .VALUE_OUT(val_n), .VALID_OUT(vld_n),
        .READY_IN(READY_IN), .OVERFLOW_OUT(ovf_n)
    );

    fixed_point_acc_lanes #(
        .WIDTH(W), .FRAC_BITS(3), .NUM_INPUTS(NI), .NUM_LANES(NL), .HAS_EXT_BIAS(1'b1)
    ) dut_b (
        .CLK(CLK), .RSTN(RSTN), .VALUES_IN(VALUES_IN), .EXT_VALUE_IN(EXT_VALUE_IN),
        .VALID_IN(VALID_IN), .READY_OUT(rdy_b), .VALUE_OUT(val_b), .VALID_OUT(vld_b),
        .READY_IN(READY_IN), .OVERFLOW_OUT(ovf_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, then clip or keep the low W bits. Returns {ovf, value}.
    function automatic logic [W:0] model(input logic [NI*W-1:0] v, input logic [W-1:0] b,
                                         input bit use_bias);
        int s;
        int hi;
        int lo;
        s  = use_bias ? int'($signed(b)) : 0;
        hi = (1 << (W - 1)) - 1;
        lo = -(1 << (W - 1));
        for (int n = 0; n < NI; n++) s += int'($signed(v[n*W +: W]));
`ifdef FIXED_POINT_ACC_SAT_EN
        if (s > hi) return {1'b1, hi[W-1:0]};
        if (s < lo) return {1'b1, lo[W-1:0]};
        return {1'b0, s[W-1:0]};
`else
        return {1'b0, s[W-1:0]};
`endif
    endfunction

    function automatic logic [NI*W-1:0] rand_vec();
        logic [NI*W-1:0] v;
        for (int n = 0; n < NI; n++) v[n*W +: W] = W'($urandom);
        return v;
    endfunction

    // One full transaction: offer, scramble inputs after acceptance, measure latency,
    // optionally stall the result, then complete the handshake.
    task automatic run_vec(input string name, input logic [NI*W-1:0] v, input logic [W-1:0] b,
                           input int hold, input bit rdy_early);
        logic [W:0] exp_n, exp_b;
        int guard;
        int lat;
        exp_n = model(v, b, 1'b0);
        exp_b = model(v, b, 1'b1);
        guard = 0;
        while (!(rdy_n && rdy_b) && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check({name, "/ready_n"}, 32'(rdy_n), 32'd1);
        check({name, "/ready_b"}, 32'(rdy_b), 32'd1);
        VALUES_IN    = v;
        EXT_VALUE_IN = b;
        VALID_IN     = 1'b1;
        READY_IN     = rdy_early;
        @(negedge CLK);
        VALID_IN     = 1'b0;
        VALUES_IN    = rand_vec();
        EXT_VALUE_IN = W'($urandom);
        check({name, "/busy"}, 32'(rdy_n), 32'd0);
        lat = 0;
        while (!vld_n && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check({name, "/latency"}, 32'(lat), 32'(K + 1));
        check({name, "/valid_b"}, 32'(vld_b), 32'd1);
        check({name, "/value_n"}, 32'(val_n), 32'(exp_n[W-1:0]));
        check({name, "/ovf_n"}, 32'(ovf_n), 32'(exp_n[W]));
        check({name, "/value_b"}, 32'(val_b), 32'(exp_b[W-1:0]));
        check({name, "/ovf_b"}, 32'(ovf_b), 32'(exp_b[W]));
        for (int i = 0; i < hold; i++) begin
            if (i == 0) begin
                VALUES_IN = rand_vec();
                VALID_IN  = 1'b1;
            end
            @(negedge CLK);
            VALID_IN = 1'b0;
            check({name, "/hold_value"}, 32'(val_n), 32'(exp_n[W-1:0]));
            check({name, "/hold_valid"}, 32'(vld_n), 32'd1);
            check({name, "/hold_ready"}, 32'(rdy_n), 32'd0);
        end
        READY_IN = 1'b1;
        @(negedge CLK);
        READY_IN = 1'b0;
        check({name, "/done_valid_n"}, 32'(vld_n), 32'd0);
        check({name, "/done_ready_n"}, 32'(rdy_n), 32'd1);
        check({name, "/done_valid_b"}, 32'(vld_b), 32'd0);
        check({name, "/done_ready_b"}, 32'(rdy_b), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "/rdy"}, 32'({rdy_n, rdy_b}), 32'd0);
        check({name, "/vld"}, 32'({vld_n, vld_b}), 32'd0);
        check({name, "/ovf"}, 32'({ovf_n, ovf_b}), 32'd0);
        check({name, "/val"}, 32'({val_n, val_b}), 32'd0);
    endtask

    initial begin
        logic [NI*W-1:0] v;
        logic [NI*W-1:0] ramp;

        for (int n = 0; n < NI; n++) ramp[n*W +: W] = W'(n);

        #12;
        check_all_zero("reset");
        @(negedge CLK);
        RSTN = 1'b1;
        #1 check("post_reset_rdy0", 32'(rdy_n), 32'd0);
        @(negedge CLK);
        check("post_reset_rdy1", 32'(rdy_n), 32'd1);

        // All operands 1.0: sum 16.0 overflows Q4.3
        for (int n = 0; n < NI; n++) v[n*W +: W] = 8'h08;
        run_vec("ones", v, 8'h00, 0, 1'b0);

        // Ramp 0..15 -> 120 = 0x78, with minimum-period handshake
        run_vec("ramp", ramp, 8'h00, 0, 1'b1);

        // Alternating extremes: lane partial sums exceed WIDTH, total -8
        for (int n = 0; n < NI; n++) v[n*W +: W] = n[0] ? 8'h80 : 8'h7F;
        run_vec("alt", v, 8'h00, 0, 1'b0);

        // Bias cancels the operands; bias changed after acceptance must not matter
        for (int n = 0; n < NI; n++) v[n*W +: W] = 8'h01;
        run_vec("bias", v, 8'hF0, 0, 1'b0);

        // Stalled result with an ignored VALID_IN pulse
        run_vec("stall", ramp, 8'h05, 10, 1'b0);

        // Reset two cycles into ACCUMULATE
        VALUES_IN = ramp;
        VALID_IN  = 1'b1;
        @(negedge CLK);
        VALID_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RSTN = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge CLK);
        @(negedge CLK);
        RSTN = 1'b1;
        #1 check("midreset_rel_rdy0", 32'(rdy_n), 32'd0);
        @(negedge CLK);
        check("midreset_rel_rdy1", 32'(rdy_n), 32'd1);
        check("midreset_no_valid", 32'(vld_n), 32'd0);
        run_vec("after_reset", ramp, 8'h00, 0, 1'b0);

        // Random vectors, random bias, random stall and handshake style
        for (int r = 0; r < 24; r++) begin
            int  hold;
            bit  early;
            logic [NI*W-1:0] rv;
            rv = rand_vec();
            if (r % 3 == 0) begin
                for (int n = 0; n < NI; n++) rv[n*W +: W] = W'($urandom_range(0, 15)) - 8'd8;
            end
            early = 1'($urandom_range(0, 1));
            hold  = early ? 0 : $urandom_range(0, 3);
            run_vec($sformatf("rand%0d", r), rv, W'($urandom), hold, early);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
